// File: rtl/regfile_wb_sched_pkg.sv
// regfile_wb_sched_pkg: shared widths, port indices and writeback request type.
package regfile_wb_sched_pkg;
  localparam int WB_DW = 64;
  localparam int WB_AW = 5;
  localparam int PORT_ALU = 0;
  localparam int PORT_MEM = 1;
  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: writeback, issue and register-file write bundle.
interface regfile_wb_sched_if
  import regfile_wb_sched_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW
);
  logic          A_VALID, A_READY;
  logic [AW-1:0] A_ADDR;
  logic [DW-1:0] A_DATA;
  logic          M_VALID, M_READY;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DATA;
  logic          ISS_VALID, ISS_STALL;
  logic [AW-1:0] ISS_DADDR, ISS_SADDR, ISS_TADDR;
  logic          D_EN;
  logic [AW-1:0] D_Addr;
  logic [DW-1:0] D;
  modport slave (
    input  A_VALID, A_ADDR, A_DATA, M_VALID, M_ADDR, M_DATA,
    input  ISS_VALID, ISS_DADDR, ISS_SADDR, ISS_TADDR,
    output A_READY, M_READY, ISS_STALL, D_EN, D_Addr, D
  );
  modport master (
    output A_VALID, A_ADDR, A_DATA, M_VALID, M_ADDR, M_DATA,
    output ISS_VALID, ISS_DADDR, ISS_SADDR, ISS_TADDR,
    input  A_READY, M_READY, ISS_STALL, D_EN, D_Addr, D
  );
endinterface

// File: rtl/regfile_wb_sched_arb.sv
// wb_arb2: 2-way writeback arbiter; round-robin with WB_RR_ARB_EN, else memory port fixed priority.
module wb_arb2
  import regfile_wb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);
`ifdef WB_RR_ARB_EN
  logic       ptr_q, ptr_d;
  logic [1:0] raw;
  // ptr_q remembers the last granted port; on contention the other port wins
  always_comb begin
    raw     = &valid_i ? (ptr_q ? 2'b01 : 2'b10) : valid_i;
    grant_o = rst ? 2'b00 : raw;
    ptr_d   = |grant_o ? grant_o[PORT_MEM] : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
`else
  logic unused_clk;
  assign unused_clk = clk;
  always_comb
    grant_o = rst ? 2'b00 : {valid_i[PORT_MEM], valid_i[PORT_ALU] & ~valid_i[PORT_MEM]};
`endif
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: writeback scheduler with busy-bit scoreboard and registered RF write port.
// Arbitration policy selected by WB_RR_ARB_EN (round-robin) or fixed memory priority by default.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW
)(
  input logic              CLK,
  input logic              RESET,
  regfile_wb_sched_if.slave bus
);
  logic [1:0]      valid, grant;
  wb_req_t         req_a, req_m, sel;
  logic [2**AW-1:0] busy_q, busy_d;
  logic            stall, d_en_q, d_en_d;
  logic [AW-1:0]   d_addr_q, d_addr_d;
  logic [DW-1:0]   d_q, d_d;
  assign req_a = '{valid: bus.A_VALID, addr: bus.A_ADDR, data: bus.A_DATA};
  assign req_m = '{valid: bus.M_VALID, addr: bus.M_ADDR, data: bus.M_DATA};
  assign valid = {req_m.valid, req_a.valid};
  wb_arb2 u_arb (.clk(CLK), .rst(RESET), .valid_i(valid), .grant_o(grant));
  assign sel         = grant[PORT_MEM] ? req_m : req_a;
  assign bus.A_READY = grant[PORT_ALU];
  assign bus.M_READY = grant[PORT_MEM];
  assign stall = bus.ISS_VALID &
                 (busy_q[bus.ISS_SADDR] | busy_q[bus.ISS_TADDR] | busy_q[bus.ISS_DADDR]);
  assign bus.ISS_STALL = stall;
  // set after clear so a same-address issue and writeback leaves the bit busy
  always_comb begin
    busy_d = busy_q;
    if (|grant) busy_d[sel.addr] = 1'b0;
    if (bus.ISS_VALID && !stall) busy_d[bus.ISS_DADDR] = 1'b1;
    d_en_d   = |grant;
    d_addr_d = |grant ? sel.addr : d_addr_q;
    d_d      = |grant ? sel.data : d_q;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      busy_q   <= '0;
      d_en_q   <= 1'b0;
      d_addr_q <= '0;
      d_q      <= '0;
    end else begin
      busy_q   <= busy_d;
      d_en_q   <= d_en_d;
      d_addr_q <= d_addr_d;
      d_q      <= d_d;
    end
  assign bus.D_EN   = d_en_q;
  assign bus.D_Addr = d_addr_q;
  assign bus.D      = d_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed checks of arbitration, scoreboard stalls and reset behaviour.
module tb_regfile_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  regfile_wb_sched_if bus ();
  regfile_wb_sched dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic iss(input logic v, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    bus.ISS_VALID = v;
    bus.ISS_DADDR = d;
    bus.ISS_SADDR = s;
    bus.ISS_TADDR = t;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
  initial begin
    logic exp_m;
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd3; bus.A_DATA = 64'h33;
    bus.M_VALID = 1'b0; bus.M_ADDR = '0;   bus.M_DATA = '0;
    iss(1'b1, 5'd3, 5'd3, 5'd3);
    tick(); tick();
    chk("rst_a_ready", bus.A_READY, 0);
    chk("rst_d_en", bus.D_EN, 0);
    chk("rst_d_addr", bus.D_Addr, 0);
    chk("rst_busy", bus.ISS_STALL, 0);
    rst = 1'b0;
    iss(1'b0, 0, 0, 0);
    #1 chk("rel_a_ready", bus.A_READY, 1);
    tick();
    chk("rel_d_en", bus.D_EN, 1);
    chk("rel_d_addr", bus.D_Addr, 3);
    chk("rel_d", bus.D, 64'h33);
    bus.A_VALID = 1'b0;
    #1 chk("novalid_ready", bus.A_READY, 0);
    tick();
    chk("idle_d_en", bus.D_EN, 0);
    chk("idle_hold_addr", bus.D_Addr, 3);
    iss(1'b1, 5'd5, 5'd1, 5'd2);
    #1 chk("iss5_accept", bus.ISS_STALL, 0);
    tick();
    iss(1'b1, 5'd6, 5'd5, 5'd6);
    #1 chk("raw5_stall", bus.ISS_STALL, 1);
    tick();
    chk("raw5_stall_hold", bus.ISS_STALL, 1);
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd5; bus.A_DATA = 64'h55;
    #1 chk("wb5_ready", bus.A_READY, 1);
    tick();
    chk("wb5_d_en", bus.D_EN, 1);
    chk("wb5_d_addr", bus.D_Addr, 5);
    chk("wb5_unstall", bus.ISS_STALL, 0);
    bus.A_VALID = 1'b0;
    iss(1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    iss(1'b0, 0, 0, 0);
    bus.M_VALID = 1'b1; bus.M_ADDR = 5'd3; bus.M_DATA = 64'h99;
    rst = 1'b1;
    #1 chk("rst_m_ready", bus.M_READY, 0);
    tick();
    chk("rst_no_d_en", bus.D_EN, 0);
    iss(1'b1, 5'd1, 5'd3, 5'd1);
    #1 chk("rst_busy3_clear", bus.ISS_STALL, 0);
    bus.M_VALID = 1'b0;
    iss(1'b0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_d_en", bus.D_EN, 0);
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd10; bus.A_DATA = 64'hA;
    bus.M_VALID = 1'b1; bus.M_ADDR = 5'd11; bus.M_DATA = 64'hB;
    for (int i = 0; i < 4; i++) begin
`ifdef WB_RR_ARB_EN
      exp_m = (i % 2) == 1;
`else
      exp_m = 1'b1;
`endif
      #1;
      chk($sformatf("arb%0d_m_ready", i), bus.M_READY, exp_m);
      chk($sformatf("arb%0d_a_ready", i), bus.A_READY, !exp_m);
      tick();
      chk($sformatf("arb%0d_d_addr", i), bus.D_Addr, exp_m ? 11 : 10);
    end
    bus.A_VALID = 1'b0; bus.M_VALID = 1'b0;
    tick();
    iss(1'b1, 5'd7, 5'd0, 5'd0);
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd7; bus.A_DATA = 64'h77;
    #1 chk("setclr7_accept", bus.ISS_STALL, 0);
    chk("setclr7_ready", bus.A_READY, 1);
    tick();
    chk("setclr7_d_en", bus.D_EN, 1);
    chk("setclr7_d_addr", bus.D_Addr, 7);
    bus.A_VALID = 1'b0;
    iss(1'b1, 5'd8, 5'd7, 5'd8);
    #1 chk("busy7_stall", bus.ISS_STALL, 1);
    iss(1'b0, 0, 0, 0);
    bus.M_VALID = 1'b1; bus.M_ADDR = 5'd0; bus.M_DATA = 64'hDEAD_BEEF_0000_0001;
    #1 chk("r0_m_ready", bus.M_READY, 1);
    chk("r0_a_ready", bus.A_READY, 0);
    tick();
    chk("r0_d_en", bus.D_EN, 1);
    chk("r0_d_addr", bus.D_Addr, 0);
    chk("r0_d", bus.D, 64'hDEAD_BEEF_0000_0001);
    bus.M_VALID = 1'b0;
    iss(1'b1, 5'd0, 5'd0, 5'd0);
    #1 chk("r0_no_busy", bus.ISS_STALL, 0);
    iss(1'b0, 0, 0, 0);
    tick();
    chk("end_d_en", bus.D_EN, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
